// File: rtl/raxi_rc256_rx_if.sv
// ---------------------------------------------------------------------------
// raxi_rc256_rx_if
// Bundles the two streaming sides of the RC receive block:
//   m_axis_rc_*  : 256-bit completion beats from the PCIe core (tready back)
//   rc_rx_*      : 288-bit frame-word write port toward the frame FIFO
// modport master : the core / downstream-FIFO side (drives beats, ff)
// modport slave  : the RC receive block (drives tready, wr, wdata)
// ---------------------------------------------------------------------------
interface raxi_rc256_rx_if;
    logic [255:0] m_axis_rc_tdata;
    logic [31:0]  m_axis_rc_tkeep;
    logic         m_axis_rc_tlast;
    logic         m_axis_rc_tvalid;
    logic         m_axis_rc_tready;
    logic         rc_rx_wr;
    logic [287:0] rc_rx_wdata;
    logic         rc_rx_ff;

    modport master (
        output m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tvalid,
        output rc_rx_ff,
        input  m_axis_rc_tready, rc_rx_wr, rc_rx_wdata
    );

    modport slave (
        input  m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tvalid,
        input  rc_rx_ff,
        output m_axis_rc_tready, rc_rx_wr, rc_rx_wdata
    );
endinterface

// File: rtl/raxi_rc256_rx.sv
// ---------------------------------------------------------------------------
// raxi_rc256_rx
// Receive side of the 256-bit PCIe requester-completion stream. Each accepted
// beat is packed into a 288-bit frame word (byte-reversed data, mod, err,
// eop, sop, parity), staged one cycle, buffered in a 2^A_DTH-entry FIFO and
// popped into the downstream write port whenever rc_rx_ff is low.
// Ports:
//   pcie_clk, pcie_rst_n : clock, async active-low reset
//   pcie_link_up         : link status; a fall mid-packet writes a terminator
//   rc (slave)           : completion stream in, frame-word write port out
//   rc_data_cnt          : internal FIFO occupancy
//   fifo_status          : {full, empty}
//   fifo_err             : pulse on FIFO overflow or illegal tkeep
//   rc_rx_cnt            : pulse per eop word written downstream
//   pkt_err_cnt          : saturating count of packets ending with err
// ---------------------------------------------------------------------------

// One DW lane: byte reversal plus the lane's parity bit.
module raxi_rc256_rx_lane (
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        par
);
    assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};
    assign par  = ^din;
endmodule

module raxi_rc256_rx #(
    parameter int         A_DTH      = 4,
    parameter logic [4:0] FULL_LEVEL = 5'd12,
    parameter logic [7:0] MAX_BEATS  = 8'd32,
    parameter int         EOP_POS    = 262,
    parameter int         ERR_POS    = 261
) (
    input  logic               pcie_clk,
    input  logic               pcie_rst_n,
    input  logic               pcie_link_up,
    raxi_rc256_rx_if.slave     rc,
    output logic [A_DTH:0]     rc_data_cnt,
    output logic [1:0]         fifo_status,
    output logic               fifo_err,
    output logic               rc_rx_cnt,
    output logic [15:0]        pkt_err_cnt
);
    localparam int NUM_LANES = 8;
    localparam int VEC_W     = 32;
    localparam int DEPTH     = 1 << A_DTH;

    typedef struct packed {
        logic [8:0]   par;
        logic [14:0]  rsvd;
        logic         sop;
        logic         eop;
        logic         err;
        logic [4:0]   mod;
        logic [255:0] data;
    } word_t;

    typedef enum logic [1:0] {IDLE, BODY, DROP} st_t;

    st_t                          st, st_nxt;
    logic [7:0]                   beat_cnt, bc_nxt;
    logic                         tready_q, link_d;
    logic                         acc, keep_ok, link_fall, trunc;
    logic                         wr_beat, wr_syn, o_sop, o_eop, o_err;
    logic [5:0]                   pop;
    logic [NUM_LANES-1:0][VEC_W-1:0] dout_lanes;
    logic [NUM_LANES-1:0]         lane_par;
    word_t                        word, stg_word;
    logic                         stg_vld;
    logic [287:0]                 mem [DEPTH];
    logic [A_DTH-1:0]             wr_ptr, rd_ptr;
    logic [A_DTH:0]               cnt, cnt_nxt;
    logic                         full, empty, push, pop_en, ovf;
    logic                         wr_q;
    logic [287:0]                 wdata_q;

    assign acc       = rc.m_axis_rc_tvalid & tready_q;
    assign link_fall = link_d & ~pcie_link_up;
    assign trunc     = (beat_cnt + 8'd1) == MAX_BEATS;

    // Last beat: contiguous mask 2^n-1 (n>=1); other beats: all ones.
    assign keep_ok = rc.m_axis_rc_tlast
                   ? (rc.m_axis_rc_tkeep[0] &
                      ((rc.m_axis_rc_tkeep & (rc.m_axis_rc_tkeep + 32'd1)) == 32'd0))
                   : (&rc.m_axis_rc_tkeep);

    // Output DW k is input DW(7-k) byte-reversed: a full 32-byte reversal.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        raxi_rc256_rx_lane u_lane (
            .din  (rc.m_axis_rc_tdata[VEC_W*(NUM_LANES-1-k) +: VEC_W]),
            .dout (dout_lanes[k]),
            .par  (lane_par[k])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) pop = pop + 6'(rc.m_axis_rc_tkeep[i]);
    end

    // ---------------- packet FSM ----------------
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            st       <= IDLE;
            beat_cnt <= '0;
        end else begin
            st       <= st_nxt;
            beat_cnt <= bc_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        bc_nxt = beat_cnt;
        case (st)
            IDLE: if (acc) begin
                bc_nxt = 8'd1;
                if (!rc.m_axis_rc_tlast) st_nxt = BODY;
            end
            BODY: if (link_fall) begin
                st_nxt = IDLE;
            end else if (acc) begin
                bc_nxt = beat_cnt + 8'd1;
                if (rc.m_axis_rc_tlast) st_nxt = IDLE;
                else if (trunc)         st_nxt = DROP;
            end
            // A link loss while discarding also abandons the packet.
            DROP: if (link_fall || (acc && rc.m_axis_rc_tlast)) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // A link fall in BODY takes precedence over a beat in the same cycle:
    // the packet is being terminated, so that beat is not written.
    always_comb begin
        wr_beat = 1'b0;
        wr_syn  = 1'b0;
        o_sop   = 1'b0;
        o_eop   = 1'b0;
        o_err   = 1'b0;
        case (st)
            IDLE: if (acc) begin
                wr_beat = 1'b1;
                o_sop   = 1'b1;
                o_eop   = rc.m_axis_rc_tlast;
                o_err   = ~keep_ok;
            end
            BODY: if (link_fall) begin
                wr_syn = 1'b1;
                o_eop  = 1'b1;
                o_err  = 1'b1;
            end else if (acc) begin
                wr_beat = 1'b1;
                o_eop   = rc.m_axis_rc_tlast | trunc;
                o_err   = ~keep_ok | (trunc & ~rc.m_axis_rc_tlast);
            end
            default: ;
        endcase
    end

    // ---------------- frame word ----------------
    always_comb begin
        word = '0;
        if (!wr_syn) begin
            word.data     = dout_lanes;
            word.mod      = 5'd0 - pop[4:0];   // (32 - popcount) mod 32
            word.par[7:0] = lane_par;
        end
        word.sop    = o_sop;
        word.eop    = o_eop;
        word.err    = o_err;
        word.par[8] = ^{word.rsvd, word.sop, word.eop, word.err, word.mod};
    end

    // ---------------- FIFO ----------------
    assign full    = cnt == (A_DTH+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign push    = stg_vld & ~full;
    assign ovf     = stg_vld & full;
    assign pop_en  = ~empty & ~rc.rc_rx_ff;
    assign cnt_nxt = cnt + (A_DTH+1)'(push) - (A_DTH+1)'(pop_en);

    always_ff @(posedge pcie_clk) begin
        if (push) mem[wr_ptr] <= stg_word;
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            link_d      <= 1'b0;
            stg_vld     <= 1'b0;
            stg_word    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            tready_q    <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rc_rx_cnt   <= 1'b0;
            fifo_err    <= 1'b0;
            pkt_err_cnt <= '0;
        end else begin
            link_d  <= pcie_link_up;
            stg_vld <= wr_beat | wr_syn;
            if (wr_beat | wr_syn) stg_word <= word;
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            cnt      <= cnt_nxt;
            // Registered pacing; the gap to DEPTH absorbs the staged beat,
            // the beat in flight and a link-loss terminator.
            tready_q <= pcie_link_up & (cnt_nxt < (A_DTH+1)'(FULL_LEVEL));
            wr_q     <= pop_en;
            if (pop_en) wdata_q <= mem[rd_ptr];
            rc_rx_cnt <= pop_en & mem[rd_ptr][EOP_POS];
            fifo_err  <= ovf | (wr_beat & ~keep_ok);
            if (stg_vld && stg_word[EOP_POS] && stg_word[ERR_POS] && pkt_err_cnt != 16'hffff)
                pkt_err_cnt <= pkt_err_cnt + 16'd1;
        end
    end

    assign rc.m_axis_rc_tready = tready_q;
    assign rc.rc_rx_wr         = wr_q;
    assign rc.rc_rx_wdata      = wdata_q;
    assign rc_data_cnt         = cnt;
    assign fifo_status         = {full, empty};
endmodule

// File: tb/tb_raxi_rc256_rx.sv
// ---------------------------------------------------------------------------
// tb_raxi_rc256_rx
// Directed and randomized completion traffic against a packet-level
// reference model; received frame words are compared in order.
// ---------------------------------------------------------------------------
module tb_raxi_rc256_rx;
    localparam int MAXB = 32;
    localparam int FL   = 12;

    logic pcie_clk = 1'b0;
    logic pcie_rst_n = 1'b0;
    logic pcie_link_up = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    raxi_rc256_rx_if rc_if ();
    logic [4:0]  rc_data_cnt;
    logic [1:0]  fifo_status;
    logic        fifo_err, rc_rx_cnt;
    logic [15:0] pkt_err_cnt;

    raxi_rc256_rx dut (
        .pcie_clk     (pcie_clk),
        .pcie_rst_n   (pcie_rst_n),
        .pcie_link_up (pcie_link_up),
        .rc           (rc_if),
        .rc_data_cnt  (rc_data_cnt),
        .fifo_status  (fifo_status),
        .fifo_err     (fifo_err),
        .rc_rx_cnt    (rc_rx_cnt),
        .pkt_err_cnt  (pkt_err_cnt)
    );

    int total = 0, bad = 0;
    logic [287:0] rxq[$], expq[$];
    int rx_base = 0, ex_base = 0;
    int n_eop = 0, n_ferr = 0;
    int exp_eop = 0, exp_ferr = 0, exp_perr = 0;
    int m_idx = 0;
    bit m_drop = 0;

    always @(negedge pcie_clk) begin
        if (rc_if.rc_rx_wr) rxq.push_back(rc_if.rc_rx_wdata);
        if (rc_rx_cnt) n_eop++;
        if (fifo_err)  n_ferr++;
    end

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int n);
        logic [32:0] m;
        m = (33'd1 << n) - 33'd1;
        return m[31:0];
    endfunction

    function automatic bit is_mask(input logic [31:0] k);
        for (int n = 1; n <= 32; n++) if (k == mask(n)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Frame word straight from the format rules.
    function automatic logic [287:0] mk(input logic [255:0] d, input logic [31:0] k,
                                        input bit sop, input bit eop, input bit err, input bit syn);
        logic [287:0] w;
        w = '0;
        if (!syn) begin
            for (int b = 0; b < 32; b++) w[8*b +: 8] = d[8*(31-b) +: 8];
            w[260:256] = 5'((32 - $countones(k)) % 32);
        end
        w[261] = err;
        w[262] = eop;
        w[263] = sop;
        for (int i = 0; i < 8; i++) w[279+i] = ^w[32*i +: 32];
        w[287] = ^w[278:256];
        return w;
    endfunction

    task automatic model_beat(input logic [255:0] d, input logic [31:0] k, input bit l);
        bit legal, eop, err;
        if (m_drop) begin
            if (l) m_drop = 0;
            return;
        end
        m_idx++;
        legal = l ? is_mask(k) : (k == 32'hffffffff);
        eop = l || (m_idx == MAXB);
        err = !legal || (!l && m_idx == MAXB);
        expq.push_back(mk(d, k, m_idx == 1, eop, err, 0));
        if (!legal) exp_ferr++;
        if (eop) begin
            exp_eop++;
            if (err) exp_perr++;
            m_idx = 0;
            if (!l) m_drop = 1;
        end
    endtask

    task automatic model_link_drop();
        if (m_idx > 0) begin
            expq.push_back(mk('0, '0, 0, 1, 1, 1));
            exp_eop++;
            exp_perr++;
            m_idx = 0;
        end
        m_drop = 0;
    endtask

    task automatic send(input logic [255:0] d, input logic [31:0] k, input bit l);
        int n = 0;
        @(negedge pcie_clk);
        rc_if.m_axis_rc_tdata  = d;
        rc_if.m_axis_rc_tkeep  = k;
        rc_if.m_axis_rc_tlast  = l;
        rc_if.m_axis_rc_tvalid = 1'b1;
        while (!rc_if.m_axis_rc_tready && n < 300) begin
            @(negedge pcie_clk);
            n++;
        end
        if (n >= 300) begin
            chk("send_timeout", 1'b1, 1'b0);
        end else begin
            @(posedge pcie_clk);
            model_beat(d, k, l);
        end
        #1 rc_if.m_axis_rc_tvalid = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int n = 0;
        while ((rxq.size() - rx_base) < (expq.size() - ex_base) && n < 600) begin
            @(negedge pcie_clk);
            n++;
        end
        repeat (6) @(negedge pcie_clk);
        chk({tag, " nwords"}, rxq.size() - rx_base, expq.size() - ex_base);
        for (int i = 0; rx_base + i < rxq.size() && ex_base + i < expq.size(); i++)
            chk($sformatf("%s word%0d", tag, i), rxq[rx_base+i], expq[ex_base+i]);
        rx_base = rxq.size();
        ex_base = expq.size();
        chk({tag, " pkt_err_cnt"}, pkt_err_cnt, exp_perr);
        chk({tag, " eop_pulses"}, n_eop, exp_eop);
        chk({tag, " fifo_err_pulses"}, n_ferr, exp_ferr);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " tready"}, rc_if.m_axis_rc_tready, 1'b0);
        chk({tag, " wr"}, rc_if.rc_rx_wr, 1'b0);
        chk({tag, " wdata"}, rc_if.rc_rx_wdata, '0);
        chk({tag, " status"}, fifo_status, 2'b01);
        chk({tag, " cnt"}, rc_data_cnt, 5'd0);
        chk({tag, " fifo_err"}, fifo_err, 1'b0);
        chk({tag, " rx_cnt"}, rc_rx_cnt, 1'b0);
        chk({tag, " pkt_err"}, pkt_err_cnt, 16'd0);
    endtask

    initial begin
        logic [255:0] d;
        int saw_full, viol, len;
        logic [31:0] k;

        rc_if.m_axis_rc_tdata  = '0;
        rc_if.m_axis_rc_tkeep  = '0;
        rc_if.m_axis_rc_tlast  = 1'b0;
        rc_if.m_axis_rc_tvalid = 1'b0;
        rc_if.rc_rx_ff         = 1'b0;
        pcie_link_up           = 1'b1;

        // reset state
        repeat (2) @(negedge pcie_clk);
        reset_checks("rst");
        pcie_rst_n = 1'b1;
        @(negedge pcie_clk);
        chk("rst tready_up", rc_if.m_axis_rc_tready, 1'b1);

        // single-beat packet, latency and field checks
        d = '0;
        d[31:0] = 32'h11223344;
        send(d, 32'h0000ffff, 1'b1);
        @(negedge pcie_clk);
        chk("lat wr+0", rc_if.rc_rx_wr, 1'b0);
        @(negedge pcie_clk);
        chk("lat wr+1", rc_if.rc_rx_wr, 1'b0);
        @(negedge pcie_clk);
        chk("lat wr+2", rc_if.rc_rx_wr, 1'b1);
        chk("single rx_cnt", rc_rx_cnt, 1'b1);
        chk("single mod", rc_if.rc_rx_wdata[260:256], 5'd16);
        chk("single dw7", rc_if.rc_rx_wdata[255:224], 32'h44332211);
        chk("single sop_eop_err", rc_if.rc_rx_wdata[263:261], 3'b110);
        drain_check("single");

        // back-pressure: downstream full for 20 cycles
        saw_full = 0;
        viol = 0;
        fork
            begin
                for (int p = 0; p < 6; p++)
                    for (int b = 0; b < 3; b++)
                        send(rnd256(), (b == 2) ? mask($urandom_range(1, 32)) : 32'hffffffff, b == 2);
            end
            begin
                rc_if.rc_rx_ff = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    @(negedge pcie_clk);
                    if (rc_data_cnt >= FL) begin
                        saw_full = 1;
                        if (rc_if.m_axis_rc_tready) viol++;
                    end
                end
                rc_if.rc_rx_ff = 1'b0;
            end
        join
        chk("bp saw_full", saw_full, 1);
        chk("bp tready_low", viol, 0);
        drain_check("bp");

        // 40-beat packet truncated at MAX_BEATS
        for (int b = 0; b < 40; b++)
            send(rnd256(), (b == 39) ? mask($urandom_range(1, 32)) : 32'hffffffff, b == 39);
        begin
            int n = 0;
            while ((rxq.size() - rx_base) < 32 && n < 200) begin
                @(negedge pcie_clk);
                n++;
            end
        end
        repeat (6) @(negedge pcie_clk);
        chk("trunc nwords", rxq.size() - rx_base, 32);
        if (rxq.size() >= rx_base + 32)
            chk("trunc last eop_err", rxq[rx_base+31][262:261], 2'b11);
        chk("trunc pkt_err", pkt_err_cnt, 16'd1);
        drain_check("trunc");

        // illegal tkeep on last beat
        send(rnd256(), 32'hffffffff, 1'b0);
        send(rnd256(), 32'h0000ff0f, 1'b1);
        drain_check("badkeep");
        chk("badkeep pkt_err", pkt_err_cnt, 16'd2);

        // link loss after beat 2 of a 4-beat packet
        send(rnd256(), 32'hffffffff, 1'b0);
        send(rnd256(), 32'hffffffff, 1'b0);
        @(negedge pcie_clk);
        @(posedge pcie_clk);
        #1 pcie_link_up = 1'b0;
        model_link_drop();
        @(negedge pcie_clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge pcie_clk);
            chk($sformatf("linkdn tready%0d", c), rc_if.m_axis_rc_tready, 1'b0);
        end
        drain_check("linkdn");
        pcie_link_up = 1'b1;
        send(rnd256(), mask($urandom_range(1, 32)), 1'b1);
        drain_check("linkup");

        // randomized packets with random downstream stalls
        fork
            begin
                for (int p = 0; p < 15; p++) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) begin
                        if (b == len - 1)
                            k = ($urandom_range(0, 5) == 0) ? $urandom : mask($urandom_range(1, 32));
                        else
                            k = ($urandom_range(0, 5) == 0) ? (32'hffffffff ^ (32'd1 << $urandom_range(0, 31)))
                                                            : 32'hffffffff;
                        send(rnd256(), k, b == len - 1);
                    end
                end
            end
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge pcie_clk);
                    rc_if.rc_rx_ff = ($urandom_range(0, 2) == 0);
                end
                rc_if.rc_rx_ff = 1'b0;
            end
        join
        drain_check("rand");

        // reset mid-packet
        send(rnd256(), 32'hffffffff, 1'b0);
        drain_check("mid pre");
        rc_if.rc_rx_ff = 1'b1;
        send(rnd256(), 32'hffffffff, 1'b0);
        send(rnd256(), 32'hffffffff, 1'b0);
        @(negedge pcie_clk);
        @(negedge pcie_clk);
        @(posedge pcie_clk);
        #3 pcie_rst_n = 1'b0;
        #1 reset_checks("midrst");
        while (expq.size() > ex_base) void'(expq.pop_back());
        m_idx = 0;
        m_drop = 0;
        exp_perr = 0;
        rc_if.rc_rx_ff = 1'b0;
        @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        send(rnd256(), mask($urandom_range(1, 32)), 1'b1);
        drain_check("post");
        if (rxq.size() > 0)
            chk("post sop", rxq[rxq.size()-1][263], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/raxi_rc256_rx.md
Name: raxi_rc256_rx

Overview:
- Receive side of the 256-bit PCIe requester interface: accepts completion beats on m_axis_rc_* from the PCIe IP core and writes them into a downstream frame FIFO write port.
- Packs each beat into the team's 288-bit frame word: DW byte-swapped data, mod, err, eop, sop, parity.
- Buffers beats in an internal synchronous FIFO and paces the core with tready.
- Enforces packet framing: length limit, tkeep legality, and link-down truncation.

Parameters:
- A_DTH, 4, internal FIFO address width; depth is 2^A_DTH entries.
- FULL_LEVEL, 5'd12, occupancy at or above which tready is deasserted.
- MAX_BEATS, 8'd32, maximum beats per packet before forced truncation.
- EOP_POS, 262, eop bit position in the 288-bit word.
- ERR_POS, 261, err bit position in the 288-bit word.

Ports:
- pcie_clk  in  1  the single clock.
- pcie_rst_n  in  1  asynchronous active-low reset.
- pcie_link_up  in  1  PCIe link status.
- m_axis_rc_tdata  in  256  completion data from the core.
- m_axis_rc_tkeep  in  32  byte enables, contiguous from bit 0.
- m_axis_rc_tlast  in  1  end of packet.
- m_axis_rc_tvalid  in  1  beat valid.
- m_axis_rc_tready  out  1  beat accept, registered.
- rc_rx_wr  out  1  downstream write strobe, registered.
- rc_rx_wdata  out  288  downstream word, registered.
- rc_rx_ff  in  1  downstream almost-full.
- rc_data_cnt  out  A_DTH+1  internal FIFO occupancy.
- fifo_status  out  2  {full, empty} of the internal FIFO.
- fifo_err  out  1  one-cycle pulse on overflow or protocol error.
- rc_rx_cnt  out  1  one-cycle pulse per eop written downstream.
- pkt_err_cnt  out  16  saturating count of errored packets.

Behaviour:
- Reset values:
  - tready=0, rc_rx_wr=0, rc_rx_wdata=0.
  - FIFO empty, so fifo_status=2'b01 and rc_data_cnt=0.
  - fifo_err=0, rc_rx_cnt=0, pkt_err_cnt=0.
  - FSM in IDLE, beat counter 0.
- Accept: a beat is taken when tvalid&tready.
- tready register: next value is pcie_link_up & (next occupancy < FULL_LEVEL). Default margin guarantees no overflow.
- Overflow: a write while full is dropped and pulses fifo_err.
- Word format:
  - [255:0] is tdata with the bytes of each DW reversed: out DW k byte j = in DW(7-k) byte(3-j), i.e. a full 256-bit byte reversal.
  - [260:256] mod = 32 − popcount(tkeep), mod 32. 32'hffffffff gives 0; 32'h1 gives 31.
  - [261] err, [262] eop, [263] sop.
  - [278:264] = 0.
  - [287:279] even parity: bit i = XOR of bits [32i+31:32i] for i=0..7; bit 8 = XOR of [278:256].
- tkeep legality:
  - A non-last beat must have tkeep=all ones.
  - A last beat must have tkeep = 2^n−1 with n in 1..32.
  - A violation sets err on that beat and pulses fifo_err.
- Packet FSM states: IDLE, BODY, DROP.
  - IDLE, accepted beat: sop=1, beat_cnt=1. If tlast, stay in IDLE; otherwise go to BODY.
  - BODY, accepted beat: beat_cnt+1. If tlast, go to IDLE.
  - BODY, beat reaches MAX_BEATS without tlast: write it with eop=1, err=1, then go to DROP.
  - DROP: accept and discard beats (no write) until tlast, then go to IDLE.
  - Link loss: pcie_link_up falling while in BODY writes a synthetic beat (data 0, mod 0, eop=1, err=1), then the FSM goes to IDLE. The FULL_LEVEL margin reserves the slot.
- Error counting:
  - Any packet whose eop beat carries err increments pkt_err_cnt; the counter saturates at 16'hffff.
  - A packet ending in DROP counts once, at truncation.
- Read side: at each edge, if the FIFO is non-empty and rc_rx_ff=0, pop the head into rc_rx_wdata and set rc_rx_wr=1; otherwise rc_rx_wr=0 and wdata holds.
- Latency: 2 clocks minimum from the accept edge to rc_rx_wr high.
- rc_rx_cnt pulses in the same cycle as rc_rx_wr of an eop word.
- Simultaneous push and pop: occupancy is unchanged. Pop from empty never occurs.
- Mid-operation reset clears everything asynchronously. A partial packet is lost and no terminator is written.

Test Plan:
- Single-beat packet, tkeep=32'h0000ffff, tdata DW0=32'h11223344: rc_rx_wr at +2 clocks; mod=16, sop=eop=1, err=0; wdata[255:224]=32'h44332211; parity correct; rc_rx_cnt pulses once.
- Three-beat packet with rc_rx_ff held 1 for 20 cycles: after 12 beats buffered, tready drops within 1 clock; no fifo_err; all beats drain in order once ff=0.
- 40-beat packet without tlast until beat 40, MAX_BEATS=32: 32 words written, word 32 has eop=1 and err=1; beats 33–40 are discarded; pkt_err_cnt=1.
- tkeep=32'h0000ff0f on the last beat: that word has err=1, fifo_err pulses, pkt_err_cnt increments.
- pcie_link_up dropped after beat 2 of a 4-beat packet: a third word with data 0, eop=1, err=1 is written; tready=0 while the link is down; FSM returns to IDLE.
- pcie_rst_n asserted mid-packet: all outputs go to reset values immediately; the next packet after release is delivered with sop=1.
